tdm_demux4: RTL and testbench

- Receive end of a 4-channel time-division-multiplexed serial link; the inverse of the team's 4:1 channel mux.
- Serial bits arrive one per valid cycle in 4-slot frames; slot index {s1,s0} = 0..3 maps to channels 0..3.
- Each channel's bits are assembled MSB-first into WORD_W-bit words across WORD_W frames, and all four words are presented together.
- Includes frame-sync hunt/lock logic and sync-error reporting.

---
 rtl/tdm_demux4_if.sv | 27 ++
 rtl/tdm_demux4.sv | 109 ++++++++++
 tb/tb_tdm_demux4.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_if.sv
// Serial-link and word-output bundle for the 4-channel TDM receiver.
// The link side drives din/din_valid/frame_sync; the receiver drives the rest.
interface tdm_demux4_if #(
  parameter int WORD_W = 8
);
  logic              din;
  logic              din_valid;
  logic              frame_sync;
  logic [WORD_W-1:0] ch0;
  logic [WORD_W-1:0] ch1;
  logic [WORD_W-1:0] ch2;
  logic [WORD_W-1:0] ch3;
  logic              word_valid;
  logic              sync_err;
  logic              locked;
  logic [1:0]        slot;

  modport master (
    output din, din_valid, frame_sync,
    input  ch0, ch1, ch2, ch3, word_valid, sync_err, locked, slot
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch0, ch1, ch2, ch3, word_valid, sync_err, locked, slot
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer: assembles MSB-first words per slot, with frame-sync hunt/lock.
//   state  | meaning
//   HUNT   | discarding bits until a frame_sync marks slot 0
//   LOCKED | aligned; each valid bit goes to the shift register of the current slot
module tdm_demux4 #(
  parameter int WORD_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  tdm_demux4_if.slave  bus
);
  localparam int CW = $clog2(WORD_W);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sh_q [4];
  logic [WORD_W-1:0] sh_d [4];
  logic [WORD_W-1:0] ch_q [4];
  logic [WORD_W-1:0] ch_d [4];
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]        slot_q, slot_d;
  logic              word_valid_q, word_valid_d;
  logic              sync_err_q, sync_err_d;
  logic [WORD_W-1:0] shifted;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    ch_d         = ch_q;
    bit_cnt_d    = bit_cnt_q;
    slot_d       = slot_q;
    word_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    shifted      = {sh_q[slot_q][WORD_W-2:0], bus.din};
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            sh_d[0]   = {sh_q[0][WORD_W-2:0], bus.din};
            bit_cnt_d = '0;
            slot_d    = 2'd1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync && slot_q != 2'd0) begin
            // Early sync restarts the frame on this bit; the partial word is lost.
            sync_err_d = 1'b1;
            for (int k = 0; k < 4; k++) sh_d[k] = '0;
            sh_d[0]   = {{(WORD_W-1){1'b0}}, bus.din};
            bit_cnt_d = '0;
            slot_d    = 2'd1;
          end else if (!bus.frame_sync && slot_q == 2'd0) begin
            sync_err_d = 1'b1;
            for (int k = 0; k < 4; k++) sh_d[k] = '0;
            bit_cnt_d = '0;
            state_d   = HUNT;
          end else begin
            sh_d[slot_q] = shifted;
            slot_d       = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              if (bit_cnt_q == CW'(WORD_W-1)) begin
                ch_d[0]      = sh_q[0];
                ch_d[1]      = sh_q[1];
                ch_d[2]      = sh_q[2];
                ch_d[3]      = shifted;
                word_valid_d = 1'b1;
                bit_cnt_d    = '0;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      sh_q         <= '{default: '0};
      ch_q         <= '{default: '0};
      bit_cnt_q    <= '0;
      slot_q       <= 2'd0;
      word_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      ch_q         <= ch_d;
      bit_cnt_q    <= bit_cnt_d;
      slot_q       <= slot_d;
      word_valid_q <= word_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.ch0        = ch_q[0];
  assign bus.ch1        = ch_q[1];
  assign bus.ch2        = ch_q[2];
  assign bus.ch3        = ch_q[3];
  assign bus.word_valid = word_valid_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.slot       = slot_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios plus random traffic against a frame-level model.
module tb_tdm_demux4;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic reset = 1'b1;

  tdm_demux4_if #(.WORD_W(W)) bus ();
  tdm_demux4 #(.WORD_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: words accumulate arithmetically per channel; frames counted per completed slot-3 bit.
  bit m_locked;
  int m_slot, m_frames;
  int m_acc [4];
  int m_ch  [4];
  bit m_wv, m_err;
  int wv_seen, err_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_locked = 0; m_slot = 0; m_frames = 0; m_wv = 0; m_err = 0;
    for (int k = 0; k < 4; k++) begin m_acc[k] = 0; m_ch[k] = 0; end
  endfunction

  function automatic void model_update(bit r, bit v, bit fs, bit d);
    if (r) begin model_clear(); return; end
    m_wv = 0; m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        m_acc[0] = (m_acc[0] * 2 + d) % M;
        m_frames = 0; m_slot = 1; m_locked = 1;
      end
    end else if (fs && m_slot != 0) begin
      m_err = 1;
      for (int k = 0; k < 4; k++) m_acc[k] = 0;
      m_acc[0] = d; m_frames = 0; m_slot = 1;
    end else if (!fs && m_slot == 0) begin
      m_err = 1;
      for (int k = 0; k < 4; k++) m_acc[k] = 0;
      m_frames = 0; m_locked = 0;
    end else begin
      m_acc[m_slot] = (m_acc[m_slot] * 2 + d) % M;
      if (m_slot == 3) begin
        if (m_frames == W - 1) begin
          for (int k = 0; k < 4; k++) m_ch[k] = m_acc[k];
          m_wv = 1; m_frames = 0;
        end else m_frames++;
      end
      m_slot = (m_slot + 1) % 4;
    end
  endfunction

  task automatic step(input bit r, input bit v, input bit fs, input bit d);
    reset = r; bus.din_valid = v; bus.frame_sync = fs; bus.din = d;
    @(posedge clk);
    model_update(r, v, fs, d);
    #1;
    check("ch0", 32'(bus.ch0), 32'(m_ch[0]));
    check("ch1", 32'(bus.ch1), 32'(m_ch[1]));
    check("ch2", 32'(bus.ch2), 32'(m_ch[2]));
    check("ch3", 32'(bus.ch3), 32'(m_ch[3]));
    check("word_valid", 32'(bus.word_valid), 32'(m_wv));
    check("sync_err", 32'(bus.sync_err), 32'(m_err));
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("slot", 32'(bus.slot), 32'(m_slot));
    if (bus.word_valid === 1'b1) wv_seen++;
    if (bus.sync_err === 1'b1) err_seen++;
  endtask

  // Sends frames [f_lo, f_hi) of a word set; optional idle cycle before each bit.
  task automatic send_frames(input int w0, input int w1, input int w2, input int w3,
                             input int f_lo, input int f_hi, input bit gaps);
    int w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int f = f_lo; f < f_hi; f++)
      for (int s = 0; s < 4; s++) begin
        if (gaps) step(0, 0, 1'($urandom % 2), 1'($urandom % 2));
        step(0, 1, s == 0, 1'((w[s] >> (W - 1 - f)) & 1));
      end
  endtask

  initial begin
    bit fs;
    model_clear();
    bus.din = 0; bus.din_valid = 0; bus.frame_sync = 0;
    wv_seen = 0; err_seen = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Reset mid-frame
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
    step(1, 1, 0, 1); step(1, 1, 1, 1);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_slot", 32'(bus.slot), 0);
    check("rst_ch0", 32'(bus.ch0), 0);

    // Hunt then basic frames
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1'($urandom % 2));
    check("hunt_locked", 32'(bus.locked), 0);
    wv_seen = 0;
    send_frames(4'hA, 4'hF, 4'h1, 4'h6, 0, W, 0);
    check("basic_wv_cnt", 32'(wv_seen), 1);
    check("basic_ch0", 32'(bus.ch0), 32'hA);
    check("basic_ch1", 32'(bus.ch1), 32'hF);
    check("basic_ch2", 32'(bus.ch2), 32'h1);
    check("basic_ch3", 32'(bus.ch3), 32'h6);

    // Same stream with valid gaps
    wv_seen = 0;
    send_frames(4'hA, 4'hF, 4'h1, 4'h6, 0, W, 1);
    check("gap_wv_cnt", 32'(wv_seen), 1);
    check("gap_ch2", 32'(bus.ch2), 32'h1);

    // Early sync at slot 2 of frame 1
    wv_seen = 0; err_seen = 0;
    send_frames(4'h3, 4'hC, 4'h7, 4'h2, 0, 1, 0);
    step(0, 1, 1, 0); step(0, 1, 0, 1);
    send_frames(4'h5, 4'h0, 4'hE, 4'h9, 0, W, 0);
    check("early_err_cnt", 32'(err_seen), 1);
    check("early_wv_cnt", 32'(wv_seen), 1);
    check("early_locked", 32'(bus.locked), 1);
    check("early_ch0", 32'(bus.ch0), 32'h5);
    check("early_ch2", 32'(bus.ch2), 32'hE);
    check("early_ch3", 32'(bus.ch3), 32'h9);

    // Missing sync at slot 0 of frame 2
    send_frames(4'h8, 4'h4, 4'h2, 4'h1, 0, 2, 0);
    step(0, 1, 0, 1);
    check("miss_err", 32'(bus.sync_err), 1);
    check("miss_locked", 32'(bus.locked), 0);
    check("miss_ch1", 32'(bus.ch1), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      fs = (m_slot == 0);
      if ($urandom % 25 == 0) fs = ~fs;
      step(1'($urandom % 500 == 0), 1'($urandom % 4 != 0), fs, 1'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
